// File: rtl/serial_subtractor_fsm.sv
// -----------------------------------------------------------------------------
// serial_subtractor_fsm
//
// Bit-serial subtractor computing (a - b - bin) mod 2^WIDTH, one bit per clock,
// LSB first, through a 1-bit full-subtractor cell with a borrow flip-flop.
// Small datapath for wide subtraction where latency is cheaper than area.
//
// Handshake (start / busy / done):
//   start is sampled only while the FSM is in IDLE or DONE. A sampled start
//   captures a, b and bin on that edge and begins an operation. While busy=1
//   (SHIFT) start is ignored. done is a one-cycle pulse marking the cycle in
//   which diff, borrow_out and overflow first show the new result. Holding
//   start high through DONE launches the next operation immediately, giving
//   one result every WIDTH+1 cycles.
//
// Parameters:
//   WIDTH       operand/result width in bits (>= 1)
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous reset, active-high
//   start       operation request
//   a           minuend, captured on an accepted start
//   b           subtrahend, captured on an accepted start
//   bin         borrow-in, captured on an accepted start
//   busy        high while bits are being processed (SHIFT)
//   done        one-cycle pulse, result valid
//   diff        (a - b - bin) mod 2^WIDTH, held until the next completion
//   borrow_out  final borrow: unsigned a < b + bin
//   overflow    signed two's-complement overflow of the subtraction
//
// Debug visibility: the FSM state is the typed signal `state` (state_t).
// -----------------------------------------------------------------------------
module serial_subtractor_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  // Counter must hold the value WIDTH after the final increment.
  localparam int CW = $clog2(WIDTH + 1);

  // Encoding is chosen so busy and done each come straight from one state
  // register bit, keeping both outputs free of decode glitches.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t           state;
  state_t           state_next;

  // Datapath registers
  logic [WIDTH-1:0] a_sr;     // latched minuend, shifted right one bit per cycle
  logic [WIDTH-1:0] b_sr;     // latched subtrahend, shifted right one bit per cycle
  logic [WIDTH-1:0] res_sr;   // partial result, filled from the MSB end
  logic             br;       // borrow flip-flop
  logic [CW-1:0]    cnt;      // index of the bit processed on the next edge

  // Combinational helpers
  logic             accept;   // start taken on this edge
  logic             last;     // this edge processes bit WIDTH-1
  logic             d_bit;    // difference bit of the current cell
  logic             br_next;  // borrow produced by the current cell
  logic [WIDTH-1:0] res_next; // partial result after this edge's shift
  logic             ovf_next; // overflow evaluated on the final edge

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // A start here is a back-to-back request, treated exactly as in IDLE.
        if (start) begin
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (single state-bit decodes)
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = state[0];
    done = state[1];
  end

  // ---------------------------------------------------------------------------
  // Datapath combinational cell
  // ---------------------------------------------------------------------------
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == CW'(WIDTH - 1));

  always_comb begin
    d_bit   = a_sr[0] ^ b_sr[0] ^ br;
    br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

    // New bit enters at the MSB; after WIDTH shifts bit i sits at position i.
    // Written as shift-then-overwrite so WIDTH=1 needs no special case.
    res_next            = res_sr >> 1;
    res_next[WIDTH-1]   = d_bit;

    // On the final edge a_sr[0]/b_sr[0] are the operands' sign bits and d_bit
    // is the result's sign bit.
    ovf_next = (a_sr[0] != b_sr[0]) && (d_bit != a_sr[0]);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      br     <= bin;
      cnt    <= '0;
      res_sr <= '0;
    end else if (state == SHIFT) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      br     <= br_next;
      res_sr <= res_next;
      cnt    <= cnt + CW'(1);
      // Visible results move only at completion and hold until the next one.
      if (last) begin
        diff       <= res_next;
        borrow_out <= br_next;
        overflow   <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor_fsm.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor_fsm
//
// Drives three instances (WIDTH = 1, 8, 13) of serial_subtractor_fsm and checks
// them against an arithmetic reference model: directed vectors, start ignored
// while busy, back-to-back operation through DONE, reset in mid-operation,
// exhaustive WIDTH=1 and randomized operations at every width.
// -----------------------------------------------------------------------------
module tb_serial_subtractor_fsm;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic        start_1, bin_1, busy_1, done_1, borrow_1, ovf_1;
  logic [0:0]  a_1, b_1, diff_1;
  logic        start_8, bin_8, busy_8, done_8, borrow_8, ovf_8;
  logic [7:0]  a_8, b_8, diff_8;
  logic        start_13, bin_13, busy_13, done_13, borrow_13, ovf_13;
  logic [12:0] a_13, b_13, diff_13;

  serial_subtractor_fsm #(.WIDTH(1)) dut_1 (
    .clk(clk), .rst(rst), .start(start_1), .a(a_1), .b(b_1), .bin(bin_1),
    .busy(busy_1), .done(done_1), .diff(diff_1), .borrow_out(borrow_1),
    .overflow(ovf_1)
  );

  serial_subtractor_fsm #(.WIDTH(8)) dut_8 (
    .clk(clk), .rst(rst), .start(start_8), .a(a_8), .b(b_8), .bin(bin_8),
    .busy(busy_8), .done(done_8), .diff(diff_8), .borrow_out(borrow_8),
    .overflow(ovf_8)
  );

  serial_subtractor_fsm #(.WIDTH(13)) dut_13 (
    .clk(clk), .rst(rst), .start(start_13), .a(a_13), .b(b_13), .bin(bin_13),
    .busy(busy_13), .done(done_13), .diff(diff_13), .borrow_out(borrow_13),
    .overflow(ovf_13)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_passed = 0;
  logic [12:0] exp_q[$];        // expected diffs of operations in flight
  logic [12:0] held_diff [3];   // last completed diff per instance

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int idx(input int w);
    return (w == 1) ? 0 : ((w == 8) ? 1 : 2);
  endfunction

  function automatic logic [12:0] mask_of(input int w);
    logic [12:0] m;
    m = '0;
    for (int i = 0; i < w; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Reference model: plain integer arithmetic on the operands.
  task automatic model(input int w, input logic [12:0] av, input logic [12:0] bv,
                       input logic bn, output logic [12:0] df, output logic br,
                       output logic ov);
    int full;
    full = int'(av) - int'(bv) - int'(bn);
    df   = 13'(full) & mask_of(w);
    br   = (int'(av) < (int'(bv) + int'(bn)));
    ov   = (av[w-1] != bv[w-1]) && (df[w-1] != av[w-1]);
  endtask

  // ---------------------------------------------------------------------------
  // Driver / monitor tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input int w, input logic st, input logic [12:0] av,
                       input logic [12:0] bv, input logic bn);
    case (w)
      1: begin start_1 = st; a_1 = av[0]; b_1 = bv[0]; bin_1 = bn; end
      8: begin start_8 = st; a_8 = av[7:0]; b_8 = bv[7:0]; bin_8 = bn; end
      default: begin start_13 = st; a_13 = av; b_13 = bv; bin_13 = bn; end
    endcase
  endtask

  task automatic sample(input int w, output logic bsy, output logic dn,
                        output logic [12:0] df, output logic br, output logic ov);
    case (w)
      1: begin bsy = busy_1; dn = done_1; df = {12'b0, diff_1}; br = borrow_1; ov = ovf_1; end
      8: begin bsy = busy_8; dn = done_8; df = {5'b0, diff_8}; br = borrow_8; ov = ovf_8; end
      default: begin bsy = busy_13; dn = done_13; df = diff_13; br = borrow_13; ov = ovf_13; end
    endcase
  endtask

  // Scribble on the operand inputs; they must not matter outside acceptance.
  task automatic scribble(input int w);
    drive(w, 1'b0, 13'($urandom), 13'($urandom), 1'($urandom));
  endtask

  // One full operation. Called #1 after a rising edge with the DUT in IDLE or
  // DONE. Optionally re-pulses start with other operands during SHIFT.
  task automatic run_op(input int w, input logic [12:0] a_in, input logic [12:0] b_in,
                        input logic bn, input bit repulse);
    logic [12:0] av, bv, edf, df;
    logic        ebr, eov, bsy, dn, br, ov;
    av = a_in & mask_of(w);
    bv = b_in & mask_of(w);
    model(w, av, bv, bn, edf, ebr, eov);
    exp_q.push_back(edf);
    drive(w, 1'b1, av, bv, bn);
    @(posedge clk); #1;
    scribble(w);
    for (int k = 1; k <= w; k++) begin
      @(posedge clk); #1;
      sample(w, bsy, dn, df, br, ov);
      if (repulse && k == 2) drive(w, 1'b1, ~av, ~bv, ~bn);
      if (repulse && k == 3) scribble(w);
      if (k < w) begin
        check($sformatf("busy_w%0d_k%0d", w, k), 32'(bsy), 32'd1);
        check($sformatf("early_done_w%0d_k%0d", w, k), 32'(dn), 32'd0);
        if (k == 1) check($sformatf("held_diff_w%0d", w), 32'(df), 32'(held_diff[idx(w)]));
      end else begin
        edf = exp_q.pop_front();
        check($sformatf("done_w%0d", w), 32'(dn), 32'd1);
        check($sformatf("busy_at_done_w%0d", w), 32'(bsy), 32'd0);
        check($sformatf("diff_w%0d a=%0h b=%0h bin=%0b", w, av, bv, bn), 32'(df), 32'(edf));
        check($sformatf("borrow_w%0d a=%0h b=%0h bin=%0b", w, av, bv, bn), 32'(br), 32'(ebr));
        check($sformatf("ovf_w%0d a=%0h b=%0h bin=%0b", w, av, bv, bn), 32'(ov), 32'(eov));
        held_diff[idx(w)] = edf;
      end
    end
  endtask

  // Two operations with start held through DONE: second done lands WIDTH+1
  // cycles after the first.
  task automatic back_to_back(input int w, input logic [12:0] a1, input logic [12:0] b1,
                              input logic bn1, input logic [12:0] a2,
                              input logic [12:0] b2, input logic bn2);
    logic [12:0] e1, e2, df;
    logic        eb1, eo1, eb2, eo2, bsy, dn, br, ov;
    model(w, a1, b1, bn1, e1, eb1, eo1);
    model(w, a2, b2, bn2, e2, eb2, eo2);
    drive(w, 1'b1, a1, b1, bn1);
    @(posedge clk); #1;
    scribble(w);
    repeat (w) begin @(posedge clk); #1; end
    sample(w, bsy, dn, df, br, ov);
    check("b2b_done1", 32'(dn), 32'd1);
    check("b2b_diff1", 32'(df), 32'(e1));
    drive(w, 1'b1, a2, b2, bn2);
    @(posedge clk); #1;
    scribble(w);
    sample(w, bsy, dn, df, br, ov);
    check("b2b_busy2", 32'(bsy), 32'd1);
    check("b2b_diff1_held", 32'(df), 32'(e1));
    for (int k = 1; k <= w; k++) begin
      @(posedge clk); #1;
      sample(w, bsy, dn, df, br, ov);
      if (k < w) check($sformatf("b2b_early_done_k%0d", k), 32'(dn), 32'd0);
    end
    check("b2b_done2", 32'(dn), 32'd1);
    check("b2b_diff2", 32'(df), 32'(e2));
    check("b2b_borrow2", 32'(br), 32'(eb2));
    check("b2b_ovf2", 32'(ov), 32'(eo2));
    held_diff[idx(w)] = e2;
    @(posedge clk); #1;
    sample(w, bsy, dn, df, br, ov);
    check("b2b_done_pulse", 32'(dn), 32'd0);
  endtask

  // Reset asserted on the 4th cycle of SHIFT.
  task automatic reset_mid(input int w);
    logic [12:0] df;
    logic        bsy, dn, br, ov;
    int          seen;
    drive(w, 1'b1, 13'h0A5, 13'h03C, 1'b1);
    @(posedge clk); #1;
    scribble(w);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    sample(w, bsy, dn, df, br, ov);
    check("rstmid_busy", 32'(bsy), 32'd0);
    check("rstmid_done", 32'(dn), 32'd0);
    check("rstmid_diff", 32'(df), 32'd0);
    check("rstmid_borrow", 32'(br), 32'd0);
    check("rstmid_ovf", 32'(ov), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) held_diff[i] = '0;
    seen = 0;
    repeat (w + 2) begin
      @(posedge clk); #1;
      sample(w, bsy, dn, df, br, ov);
      seen = seen + int'(dn) + int'(bsy);
    end
    check("rstmid_no_activity", 32'(seen), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [12:0] df;
    logic        bsy, dn, br, ov;
    int          widths[3];
    widths = '{1, 8, 13};

    rst = 1'b1;
    drive(1, 1'b0, '0, '0, 1'b0);
    drive(8, 1'b0, '0, '0, 1'b0);
    drive(13, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) held_diff[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    foreach (widths[i]) begin
      sample(widths[i], bsy, dn, df, br, ov);
      check($sformatf("rst_busy_w%0d", widths[i]), 32'(bsy), 32'd0);
      check($sformatf("rst_done_w%0d", widths[i]), 32'(dn), 32'd0);
      check($sformatf("rst_diff_w%0d", widths[i]), 32'(df), 32'd0);
      check($sformatf("rst_borrow_w%0d", widths[i]), 32'(br), 32'd0);
      check($sformatf("rst_ovf_w%0d", widths[i]), 32'(ov), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors at WIDTH=8
    run_op(8, 13'h05, 13'h03, 1'b0, 1'b0);
    run_op(8, 13'h03, 13'h05, 1'b0, 1'b0);
    run_op(8, 13'h00, 13'h00, 1'b1, 1'b0);
    run_op(8, 13'h80, 13'h01, 1'b0, 1'b0);
    run_op(8, 13'h7F, 13'hFF, 1'b0, 1'b0);
    run_op(8, 13'hFF, 13'hFF, 1'b1, 1'b0);
    // start re-pulsed during SHIFT must be ignored
    run_op(8, 13'h5A, 13'h33, 1'b0, 1'b1);
    @(posedge clk); #1;
    back_to_back(8, 13'h40, 13'h11, 1'b1, 13'h12, 13'hC4, 1'b0);
    reset_mid(8);
    run_op(8, 13'h10, 13'h20, 1'b1, 1'b0);

    // Exhaustive WIDTH=1
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run_op(1, {12'b0, v[2]}, {12'b0, v[1]}, v[0], 1'b0);
    end
    run_op(13, 13'h1000, 13'h0001, 1'b0, 1'b0);

    // Randomized operations at every width, sometimes back-to-back via DONE
    foreach (widths[i]) begin
      for (int n = 0; n < 1000; n++) begin
        run_op(widths[i], 13'($urandom), 13'($urandom), 1'($urandom), 1'b0);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
      end
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

  // Safety net: the sequence above is bounded, this only catches a stuck sim.
  initial begin
    #5000000;
    $display("FAIL timeout: got no summary expected completion before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
